pipe_stage_elastic: RTL

Parametrised elastic pipeline stage register: the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It carries a generic data payload and a generic control-signal bundle between two pipeline stages. It replaces the plain load-enable with a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, a synchronous flush that inserts bubbles, and a saturating stall counter. It is instantiated once per stage boundary in the datapath.

---
 rtl/pipe_stage_elastic.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: valid/ready handshake with a two-entry skid buffer,
// synchronous flush that inserts bubbles, and a saturating upstream-stall counter.
module pipe_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o,
  input  logic              stall_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept_s, dequeue_s;

  assign accept_s  = in_valid_i & in_ready_o & ~flush_i;
  assign dequeue_s = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) state_d = ST_ONE;
          else          state_d = ST_EMPTY;
        end
        ST_ONE: begin
          if (accept_s && !dequeue_s)      state_d = ST_FULL;
          else if (!accept_s && dequeue_s) state_d = ST_EMPTY;
          else                             state_d = ST_ONE;
        end
        ST_FULL: begin
          if (dequeue_s) state_d = ST_ONE;
          else           state_d = ST_FULL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake and occupancy decode purely from registered state: no path from out_ready or in_valid.
  always_comb begin
    in_ready_o  = 1'b1;
    out_valid_o = 1'b0;
    occupancy_o = 2'd0;
    case (state_q)
      ST_EMPTY: begin
        in_ready_o  = 1'b1;
        out_valid_o = 1'b0;
        occupancy_o = 2'd0;
      end
      ST_ONE: begin
        in_ready_o  = 1'b1;
        out_valid_o = 1'b1;
        occupancy_o = 2'd1;
      end
      ST_FULL: begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b1;
        occupancy_o = 2'd2;
      end
      default: begin
        in_ready_o  = 1'b1;
        out_valid_o = 1'b0;
        occupancy_o = 2'd0;
      end
    endcase
    out_data_o = main_data_q;
    if (out_valid_o) out_ctrl_o = main_ctrl_q;
    else             out_ctrl_o = {CTRL_W{1'b0}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_data_q <= {DATA_W{1'b0}};
      main_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
    end else begin
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Flush zeroes held control so a stale bundle can never be presented as a live op.
  always_comb begin
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush_i) begin
      main_ctrl_d = {CTRL_W{1'b0}};
      skid_ctrl_d = {CTRL_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end else begin
            main_data_d = main_data_q;
          end
        end
        ST_ONE: begin
          if (accept_s && dequeue_s) begin
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end else if (accept_s) begin
            skid_data_d = in_data_i;
            skid_ctrl_d = in_ctrl_i;
          end else begin
            main_data_d = main_data_q;
          end
        end
        ST_FULL: begin
          if (dequeue_s) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end else begin
            main_data_d = main_data_q;
          end
        end
        default: begin
          main_data_d = main_data_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Clear wins; otherwise count refused offers, saturating at all-ones.
  always_comb begin
    if (stall_clr_i) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (in_valid_i && !in_ready_o && !flush_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
